instr_sequencer: RTL and testbench

//   Multi-cycle sequencer around the instruction decoder/ALU datapath. Owns the PC.

---
 rtl/instr_sequencer.sv | 179 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle sequencer that owns the program counter. It fetches 32-bit
//   instructions over a req/ack port and latches each one into an IR. It then
//   splits the IR fields into registered datapath controls and steps the
//   instruction through FETCH / DECODE / EXEC / WB / MEM / NEXT.
//
//   IR layout: op[31:26], reserved[25], rd[24:22], rs1[21:19], rs2[18:16],
//              i1[15:8], i2[7:0]
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         leave IDLE and begin fetching at pc
//   imem_req/ack  instruction fetch handshake, imem_rdata valid with ack
//   pc            address of the current instruction
//   alu_control   000001 = ADD, 000010 = SUB, 000000 otherwise
//   rf_raddr1/2   register read addresses (rs1 / rs2)
//   rf_waddr      register write address (rd)
//   rf_we         register write strobe, one cycle in WB
//   imm1/imm2     immediate fields
//   mem_write     data-memory write, held until mem_ack
//   busy          high in every state except IDLE and HALT
//   halted        high in HALT
//   illegal       one-cycle pulse after decoding an undefined opcode
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int              PC_W     = 16,
    parameter int              PC_STEP  = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] pc,
    output logic [5:0]      alu_control,
    output logic [2:0]      rf_raddr1,
    output logic [2:0]      rf_raddr2,
    output logic [2:0]      rf_waddr,
    output logic            rf_we,
    output logic [7:0]      imm1,
    output logic [7:0]      imm2,
    output logic            mem_write,
    input  logic            mem_ack,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    localparam logic [5:0] OP_NOP   = 6'b000000;
    localparam logic [5:0] OP_ADD   = 6'b000001;
    localparam logic [5:0] OP_SUB   = 6'b000010;
    localparam logic [5:0] OP_STORE = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_MEM,
        S_NEXT,
        S_HALT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic        op_legal;
    logic        ir_unused;

    assign opcode    = ir[31:26];
    // Bit 25 is reserved; it is latched with the rest of the IR but never used.
    assign ir_unused = ir[25];

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_NOP, OP_ADD, OP_SUB, OP_STORE, OP_HALT: op_legal = 1'b1;
            default:                                   op_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the state-decoded handshake/status outputs.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        rf_we      = 1'b0;
        mem_write  = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB: next_state = S_EXEC;
                    OP_STORE:       next_state = S_MEM;
                    OP_HALT:        next_state = S_HALT;
                    default:        next_state = S_NEXT;
                endcase
            end
            S_EXEC: next_state = S_WB;
            S_WB: begin
                rf_we      = 1'b1;
                next_state = S_NEXT;
            end
            S_MEM: begin
                mem_write = 1'b1;
                if (mem_ack) next_state = S_NEXT;
            end
            S_NEXT: next_state = S_FETCH;
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // IR, PC and the registered decode outputs. The decode fields load on
    // the DECODE edge and then hold until the next instruction is decoded,
    // so they stay stable through EXEC/WB/MEM/NEXT. The illegal flag is
    // loaded on the same edge and cleared on the following one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            ir          <= '0;
            alu_control <= '0;
            rf_raddr1   <= '0;
            rf_raddr2   <= '0;
            rf_waddr    <= '0;
            imm1        <= '0;
            imm2        <= '0;
            illegal     <= 1'b0;
        end else begin
            illegal <= 1'b0;
            if (state == S_FETCH && imem_ack) begin
                ir <= imem_rdata;
            end
            if (state == S_NEXT) begin
                pc <= pc + PC_W'(PC_STEP);
            end
            if (state == S_DECODE) begin
                rf_waddr  <= ir[24:22];
                rf_raddr1 <= ir[21:19];
                rf_raddr2 <= ir[18:16];
                imm1      <= ir[15:8];
                imm2      <= ir[7:0];
                illegal   <= !op_legal;
                case (opcode)
                    OP_ADD:  alu_control <= 6'b000001;
                    OP_SUB:  alu_control <= 6'b000010;
                    default: alu_control <= 6'b000000;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        mem_ack;

    logic        imem_req, rf_we, mem_write, busy, halted, illegal;
    logic [15:0] pc;
    logic [5:0]  alu_control;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [7:0]  imm1, imm2;

    logic        b_imem_req, b_rf_we, b_mem_write, b_busy, b_halted, b_illegal;
    logic [15:0] b_pc;
    logic [5:0]  b_alu_control;
    logic [2:0]  b_rf_raddr1, b_rf_raddr2, b_rf_waddr;
    logic [7:0]  b_imm1, b_imm2;

    int checks = 0;
    int errors = 0;
    logic [15:0] pc_model;

    typedef struct packed {
        logic [7:0]  cycles;
        logic [7:0]  req_cycles;
        logic [7:0]  we_cycles;
        logic [7:0]  mw_cycles;
        logic [7:0]  ill_cycles;
        logic [5:0]  alu;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [2:0]  wa;
        logic [7:0]  i1;
        logic [7:0]  i2;
        logic [15:0] pc_after;
        logic        halted;
    } txn_t;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .alu_control(alu_control),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .imm1(imm1), .imm2(imm2),
        .mem_write(mem_write), .mem_ack(mem_ack),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    // Second instance with a reset PC just below the wrap point; it sees the
    // same inputs, so it follows the same state trajectory with a shifted pc.
    instr_sequencer #(.RESET_PC(16'hFFFC)) dut_wrap (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(b_imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(b_pc), .alu_control(b_alu_control),
        .rf_raddr1(b_rf_raddr1), .rf_raddr2(b_rf_raddr2), .rf_waddr(b_rf_waddr),
        .rf_we(b_rf_we), .imm1(b_imm1), .imm2(b_imm2),
        .mem_write(b_mem_write), .mem_ack(mem_ack),
        .busy(b_busy), .halted(b_halted), .illegal(b_illegal)
    );

    // Reference model: what one instruction should look like end to end,
    // derived from the opcode table and the ack wait counts.
    function automatic txn_t model_txn(input logic [31:0] instr, input int aw,
                                       input int mw, input logic [15:0] pc0);
        txn_t t;
        logic [5:0] op;
        op           = instr[31:26];
        t.req_cycles = 8'(aw + 1);
        t.we_cycles  = 8'd0;
        t.mw_cycles  = 8'd0;
        t.ill_cycles = 8'd0;
        t.alu        = 6'd0;
        t.wa         = instr[24:22];
        t.ra1        = instr[21:19];
        t.ra2        = instr[18:16];
        t.i1         = instr[15:8];
        t.i2         = instr[7:0];
        t.pc_after   = pc0 + 16'd4;
        t.halted     = 1'b0;
        case (op)
            6'd1: begin t.cycles = 8'(5 + aw); t.alu = 6'd1; t.we_cycles = 8'd1; end
            6'd2: begin t.cycles = 8'(5 + aw); t.alu = 6'd2; t.we_cycles = 8'd1; end
            6'd3: begin t.cycles = 8'(4 + aw + mw); t.mw_cycles = 8'(mw + 1); end
            6'd0: t.cycles = 8'(3 + aw);
            6'd63: begin t.cycles = 8'(2 + aw); t.pc_after = pc0; t.halted = 1'b1; end
            default: begin t.cycles = 8'(3 + aw); t.ill_cycles = 8'd1; end
        endcase
        return t;
    endfunction

    // Drives one instruction starting from the first FETCH cycle and measures
    // what the DUT did until the next FETCH (or HALT).
    task automatic run_instr(input logic [31:0] instr, input int aw, input int mw,
                             output txn_t o);
        int c = 0, rq = 0, we = 0, mwc = 0, il = 0;
        bit left_fetch = 0;
        forever begin
            if (left_fetch && (imem_req === 1'b1 || halted === 1'b1)) break;
            if (c >= 60) begin
                checks++; errors++;
                $display("[TB] FAIL run_instr timeout: cycles=%0d required <60", c);
                break;
            end
            if (imem_req !== 1'b1) left_fetch = 1;
            rq  += int'(imem_req === 1'b1);
            we  += int'(rf_we === 1'b1);
            mwc += int'(mem_write === 1'b1);
            il  += int'(illegal === 1'b1);
            if (imem_req === 1'b1) begin
                imem_ack   = (rq - 1 == aw);
                imem_rdata = (rq - 1 == aw) ? instr : $urandom;
            end else begin
                imem_ack   = 1'($urandom % 2);
                imem_rdata = $urandom;
            end
            mem_ack = (mem_write === 1'b1) ? (mwc - 1 == mw) : 1'($urandom % 2);
            @(negedge clk);
            c++;
        end
        imem_ack     = 1'b0;
        mem_ack      = 1'b0;
        o.cycles     = 8'(c);
        o.req_cycles = 8'(rq);
        o.we_cycles  = 8'(we);
        o.mw_cycles  = 8'(mwc);
        o.ill_cycles = 8'(il);
        o.alu        = alu_control;
        o.ra1        = rf_raddr1;
        o.ra2        = rf_raddr2;
        o.wa         = rf_waddr;
        o.i1         = imm1;
        o.i2         = imm2;
        o.pc_after   = pc;
        o.halted     = halted;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pc_model = 16'h0000;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] obs;
        rst = 1'b1; start = 1'b0; imem_ack = 1'b0; mem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        obs = {imem_req, alu_control, rf_raddr1, rf_raddr2, rf_waddr, rf_we, imm1, imm2,
               mem_write, busy, halted, illegal, pc};
        checks++;
        if (obs !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got=%h expected=%h", obs, 64'd0);
        end
        checks++;
        if (b_pc !== 16'hFFFC) begin
            errors++;
            $display("[TB] FAIL reset_pc_param: got=%h expected=fffc", b_pc);
        end
        rst = 1'b0;
        pc_model = 16'h0000;
        @(negedge clk);
        checks++;
        if ({busy, imem_req} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy/req=%b expected=00", {busy, imem_req});
        end
    endtask

    task automatic test_one(input string name, input logic [31:0] instr,
                            input int aw, input int mw);
        txn_t o, e;
        e = model_txn(instr, aw, mw, pc_model);
        run_instr(instr, aw, mw, o);
        pc_model = e.pc_after;
        checks++;
        if (o !== e) begin
            errors++;
            $display("[TB] FAIL %s instr=%h: got=%h expected=%h", name, instr, o, e);
        end
    endtask

    task automatic test_add();
        do_start();
        checks++;
        if ({busy, imem_req} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL start_fetch: busy/req=%b expected=11", {busy, imem_req});
        end
        test_one("add", 32'h04CA0000, 0, 0);
    endtask

    task automatic test_sub();
        test_one("sub_delayed_ack", 32'h08CA0000, 3, 0);
    endtask

    task automatic test_store();
        test_one("store_delayed_ack", 32'h0C000000, 0, 2);
    endtask

    task automatic test_illegal_halt();
        logic [15:0] frozen;
        test_one("illegal", 32'h28000000, 0, 0);
        test_one("halt", 32'hFC000000, 1, 0);
        frozen = pc_model;
        for (int i = 0; i < 4; i++) begin
            start    = 1'b1;
            imem_ack = 1'($urandom % 2);
            mem_ack  = 1'($urandom % 2);
            @(negedge clk);
            checks++;
            if ({imem_req, halted, busy, pc} !== {3'b010, frozen}) begin
                errors++;
                $display("[TB] FAIL halt_hold: req/halted/busy/pc=%h expected=%h",
                         {imem_req, halted, busy, pc}, {3'b010, frozen});
            end
        end
        start = 1'b0; imem_ack = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        do_start();
        test_one("wrap_nop", 32'h00000000, 0, 0);
        checks++;
        if (b_pc !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL pc_wrap: got=%h expected=0000", b_pc);
        end
        test_one("wrap_nop2", 32'h00123456, 2, 0);
        checks++;
        if (b_pc !== 16'h0004) begin
            errors++;
            $display("[TB] FAIL pc_after_wrap: got=%h expected=0004", b_pc);
        end
    endtask

    task automatic test_mid_fetch_reset();
        do_reset();
        do_start();
        imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, busy, pc} !== {2'b00, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL mid_fetch_reset: req/busy/pc=%h expected=0",
                     {imem_req, busy, pc});
        end
        rst = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL stay_idle: req/busy=%b expected=00", {imem_req, busy});
        end
        imem_ack = 1'b0;
        pc_model = 16'h0000;
    endtask

    task automatic test_random();
        logic [31:0] instr;
        logic [5:0]  op;
        do_reset();
        do_start();
        for (int n = 0; n < 40; n++) begin
            case ($urandom % 5)
                0: op = 6'd0;
                1: op = 6'd1;
                2: op = 6'd2;
                3: op = 6'd3;
                default: begin
                    op = 6'($urandom % 64);
                    while (op <= 6'd3 || op == 6'd63) op = 6'($urandom % 64);
                end
            endcase
            instr = {op, 26'($urandom)};
            test_one("random", instr, int'($urandom % 4), int'($urandom % 4));
        end
        test_one("random_halt", {6'd63, 26'($urandom)}, int'($urandom % 4), 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_store();
        test_illegal_halt();
        test_wrap();
        test_mid_fetch_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
